uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared types and default constants for the UART TX arbiter slice.
// Contents: arbiter FSM state type and default values for NREQ, DBIT,
// TIMEOUT and TO_BITS.
package uart_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned DBIT_DEF    = 8;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned TO_BITS_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bytes in, TX FIFO write port out.
// master: requester/FIFO side (drives req_valid, req_last, req_data, tx_full)
// slave : arbiter side (drives req_ready, wr_uart, w_data)
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DBIT = DBIT_DEF
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;

  modport master (
    output req_valid, req_last, req_data, tx_full,
    input  req_ready, wr_uart, w_data
  );

  modport slave (
    input  req_valid, req_last, req_data, tx_full,
    output req_ready, wr_uart, w_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: round-robin search, first set bit of req at or above ptr, wrapping.
// Ports: req (request vector), ptr (start index) -> pick (one-hot), valid.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic             valid
);

  // Walk offsets 0..NREQ-1 from ptr; every index compare is against a
  // loop constant so no variable bit-select is needed.
  always_comb begin
    int unsigned pos;
    logic        found;
    pick  = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && (i == pos) && req[i]) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    valid = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter feeding one UART TX FIFO.
// A requester owns the FIFO from grant until its last byte is accepted;
// bytes are passed through combinationally (no buffering).
// Ports: clk, reset (sync, active-low), bus (uart_tx_arbiter_if.slave),
//        grant (one-hot owner), busy (packet in flight), timeout_tick.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to revoke a grant whose
// owner stays invalid for TIMEOUT cycles; otherwise timeout_tick is tied 0.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TO_BITS = TO_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_arbiter_if.slave      bus,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  timeout_tick
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] nxt_ptr;
  logic [NREQ-1:0]  pick;
  logic             pick_valid;
  logic             own_valid;
  logic             own_last;
  logic             xfer;
  logic             drop;
  logic [DBIT-1:0]  w_data_c;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Owner's view of the request lanes: data mux and post-packet pointer.
  always_comb begin
    w_data_c = '0;
    nxt_ptr  = rr_ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        w_data_c = w_data_c | bus.req_data[i*DBIT +: DBIT];
        nxt_ptr  = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign own_valid = |(grant & bus.req_valid);
  assign own_last  = |(grant & bus.req_last);
  assign busy      = (state_q == SEND);

  // Reset gates the strobe so an aborted packet never leaks a byte.
  assign xfer          = reset && busy && own_valid && !bus.tx_full;
  assign bus.wr_uart   = xfer;
  assign bus.req_ready = grant & {NREQ{xfer}};
  assign bus.w_data    = w_data_c;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic               tick_q, tick_d;
  assign timeout_tick = tick_q;
`else
  logic [TO_BITS-1:0] unused_to;
  assign unused_to    = TO_BITS'(TIMEOUT);
  assign timeout_tick = 1'b0;
`endif

  // Next-state: grant on IDLE, release on accepted last byte (or timeout).
  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    rr_ptr_d = rr_ptr_q;
    drop     = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d = '0;
    tick_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && own_last) begin
          drop = 1'b1;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Only an absent owner counts; tx_full stalls keep the count at 0.
        else if (!own_valid) begin
          to_cnt_d = to_cnt_q + TO_BITS'(1);
          if (to_cnt_d == TO_BITS'(TIMEOUT)) begin
            drop   = 1'b1;
            tick_d = 1'b1;
          end
        end
`endif
        if (drop) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = nxt_ptr;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant    <= '0;
      rr_ptr_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      tick_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      tick_q   <= tick_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven cycle vectors plus a grant-hold sequence.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] grant;
  logic       busy;
  logic       timeout_tick;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_arbiter_if #(.NREQ(4), .DBIT(8)) bus ();

  uart_tx_arbiter #(
    .NREQ    (4),
    .DBIT    (8),
    .TIMEOUT (4),
    .TO_BITS (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .grant        (grant),
    .busy         (busy),
    .timeout_tick (timeout_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic        chk_st;
    logic        wr;
    logic [7:0]  wdata;
    logic [3:0]  ready;
    logic [3:0]  gnt;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic f, input logic st,
                              input logic wr, input logic [7:0] wd, input logic [3:0] rd,
                              input logic [3:0] g, input logic b);
    vec_t r;
    r.rst = rst; r.valid = v; r.last = l; r.data = d; r.full = f;
    r.chk_st = st; r.wr = wr; r.wdata = wd; r.ready = rd; r.gnt = g; r.bsy = b;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic f);
    reset         = rst;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_full   = f;
  endtask

  initial begin
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);

    // Reset and post-reset idle
    tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    // req0 three-byte packet 41 42 43
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'h41, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'h41, 0, 1, 1, 8'h41, 4'h1, 4'h1, 1));
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'h42, 0, 1, 1, 8'h42, 4'h1, 4'h1, 1));
    tbl.push_back(mk(1, 4'h1, 4'h1, 32'h43, 0, 1, 1, 8'h43, 4'h1, 4'h1, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    // reset, then req1 and req3 together with single-byte packets
    tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'hA, 4'hA, 32'hA300A100, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'hA, 4'hA, 32'hA300A100, 0, 1, 1, 8'hA1, 4'h2, 4'h2, 1));
    tbl.push_back(mk(1, 4'h8, 4'h8, 32'hA300A100, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h8, 4'h8, 32'hA300A100, 0, 1, 1, 8'hA3, 4'h8, 4'h8, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    // pointer back at 0: req0 wins over req1
    tbl.push_back(mk(1, 4'h3, 4'h3, 32'h0000B1B0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h3, 4'h3, 32'h0000B1B0, 0, 1, 1, 8'hB0, 4'h1, 4'h1, 1));
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h0000B1B0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h0000B1B0, 0, 1, 1, 8'hB1, 4'h2, 4'h2, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    // req2 packet with a five-cycle tx_full stall
    tbl.push_back(mk(1, 4'h4, 4'h0, 32'h00C00000, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h4, 4'h0, 32'h00C00000, 0, 1, 1, 8'hC0, 4'h4, 4'h4, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 4'h4, 4'h0, 32'h00C10000, 1, 1, 0, 8'h00, 4'h0, 4'h4, 1));
    tbl.push_back(mk(1, 4'h4, 4'h0, 32'h00C10000, 0, 1, 1, 8'hC1, 4'h4, 4'h4, 1));
    tbl.push_back(mk(1, 4'h4, 4'h4, 32'h00C20000, 0, 1, 1, 8'hC2, 4'h4, 4'h4, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    // req0 packet (wrap from ptr 3), req1 raises valid mid-packet, req0 stalls once
    tbl.push_back(mk(1, 4'h1, 4'h0, 32'h000000D0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h3, 4'h2, 32'h0000E0D0, 0, 1, 1, 8'hD0, 4'h1, 4'h1, 1));
    tbl.push_back(mk(1, 4'h3, 4'h2, 32'h0000E0D1, 0, 1, 1, 8'hD1, 4'h1, 4'h1, 1));
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h0000E0D1, 0, 1, 0, 8'h00, 4'h0, 4'h1, 1));
    tbl.push_back(mk(1, 4'h3, 4'h3, 32'h0000E0D2, 0, 1, 1, 8'hD2, 4'h1, 4'h1, 1));
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h0000E000, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h2, 4'h2, 32'h0000E000, 0, 1, 1, 8'hE0, 4'h2, 4'h2, 1));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    // req3 four-byte packet aborted by reset after two bytes
    tbl.push_back(mk(1, 4'h8, 4'h0, 32'hF0000000, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h8, 4'h0, 32'hF0000000, 0, 1, 1, 8'hF0, 4'h8, 4'h8, 1));
    tbl.push_back(mk(1, 4'h8, 4'h0, 32'hF1000000, 0, 1, 1, 8'hF1, 4'h8, 4'h8, 1));
    tbl.push_back(mk(0, 4'h8, 4'h0, 32'hF2000000, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 32'h0, 0, 1, 0, 8'h00, 4'h0, 4'h0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].full);
      #2;
      check($sformatf("row%0d wr_uart", i), 32'(bus.wr_uart), 32'(tbl[i].wr));
      check($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      check($sformatf("row%0d timeout_tick", i), 32'(timeout_tick), 32'h0);
      if (tbl[i].wr)
        check($sformatf("row%0d w_data", i), 32'(bus.w_data), 32'(tbl[i].wdata));
      if (tbl[i].chk_st) begin
        check($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].gnt));
        check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      end
    end

    // Grant hold: req1 granted (ptr 0) then drops valid for ten cycles
    @(negedge clk);
    drive(1'b1, 4'h2, 4'h2, 32'h00005A00, 1'b0);
    #2;
    check("hold pre grant", 32'(grant), 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 4'h2, 32'h00005A00, 1'b0);
      #2;
      check($sformatf("hold%0d wr_uart", k), 32'(bus.wr_uart), 32'h0);
`ifdef UART_TX_ARB_TIMEOUT_EN
      check($sformatf("hold%0d grant", k), 32'(grant), (k < 4) ? 32'h2 : 32'h0);
      check($sformatf("hold%0d busy", k), 32'(busy), (k < 4) ? 32'h1 : 32'h0);
      check($sformatf("hold%0d timeout_tick", k), 32'(timeout_tick), (k == 4) ? 32'h1 : 32'h0);
`else
      check($sformatf("hold%0d grant", k), 32'(grant), 32'h2);
      check($sformatf("hold%0d busy", k), 32'(busy), 32'h1);
      check($sformatf("hold%0d timeout_tick", k), 32'(timeout_tick), 32'h0);
`endif
    end

    // req1 and req2 both valid with single-byte packets
    @(negedge clk);
    drive(1'b1, 4'h6, 4'h6, 32'h006B5A00, 1'b0);
    #2;
`ifndef UART_TX_ARB_TIMEOUT_EN
    check("resume wr_uart", 32'(bus.wr_uart), 32'h1);
    check("resume w_data", 32'(bus.w_data), 32'h5A);
    check("resume grant", 32'(grant), 32'h2);
    @(negedge clk);
    #2;
`endif
    check("gap wr_uart", 32'(bus.wr_uart), 32'h0);
    check("gap grant", 32'(grant), 32'h0);
    @(negedge clk);
    drive(1'b1, 4'h4, 4'h4, 32'h006B0000, 1'b0);
    #2;
    check("next wr_uart", 32'(bus.wr_uart), 32'h1);
    check("next w_data", 32'(bus.w_data), 32'h6B);
    check("next grant", 32'(grant), 32'h4);
    check("next req_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    #2;
    check("final busy", 32'(busy), 32'h0);
    check("final wr_uart", 32'(bus.wr_uart), 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
